// File: rtl/helper_axis_arbiter.sv
// Two-source round-robin AXIS arbiter with burst-locked grants.
// Each grant lasts BURST_LEN accepted beats; output_id tags the owning source.
module helper_axis_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_0_valid,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    output logic                  input_0_ready,
    input  logic                  input_1_valid,
    input  logic [DATA_WIDTH-1:0] input_1_data,
    output logic                  input_1_ready,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_last,
    output logic                  output_id,
    input  logic                  output_ready,
    output logic [1:0]            debug_state
);

    localparam int CNT_W = ($clog2(BURST_LEN) < 1) ? 1 : $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_next;
    logic             last_served, last_served_next;
    logic             cur_id;
    logic             own_valid;
    logic             other_valid;
    logic             beat;

    assign debug_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            last_served <= 1'b1;
        end else begin
            state       <= state_next;
            beat_cnt    <= beat_cnt_next;
            last_served <= last_served_next;
        end
    end

    // Pure pass-through while granted; everything reads 0 in IDLE (and thus in reset).
    always_comb begin
        output_valid  = 1'b0;
        output_data   = '0;
        output_id     = 1'b0;
        input_0_ready = 1'b0;
        input_1_ready = 1'b0;
        case (state)
            GRANT0: begin
                output_valid  = input_0_valid;
                output_data   = input_0_data;
                input_0_ready = output_ready;
            end
            GRANT1: begin
                output_valid  = input_1_valid;
                output_data   = input_1_data;
                output_id     = 1'b1;
                input_1_ready = output_ready;
            end
            default: ;
        endcase
        output_last = output_valid && (beat_cnt == LAST_CNT);
    end

    always_comb begin
        state_next       = state;
        beat_cnt_next    = beat_cnt;
        last_served_next = last_served;
        cur_id      = (state == GRANT1);
        own_valid   = cur_id ? input_1_valid : input_0_valid;
        other_valid = cur_id ? input_0_valid : input_1_valid;
        beat        = (state != IDLE) && output_valid && output_ready;
        case (state)
            IDLE: begin
                if (input_0_valid && input_1_valid)
                    state_next = last_served ? GRANT0 : GRANT1;
                else if (input_0_valid)
                    state_next = GRANT0;
                else if (input_1_valid)
                    state_next = GRANT1;
            end
            default: begin
                if (beat) begin
                    if (beat_cnt == LAST_CNT) begin
                        // Rotation is decided on the last beat so the next burst starts without a bubble.
                        beat_cnt_next    = '0;
                        last_served_next = cur_id;
                        if (other_valid)
                            state_next = cur_id ? GRANT0 : GRANT1;
                        else if (!own_valid)
                            state_next = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_helper_axis_arbiter.sv
// Bench for helper_axis_arbiter: fixed vector table, directed corner sequences,
// and random traffic checked against a burst-counting reference model.
module tb_helper_axis_arbiter;

    localparam int DW = 10;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0, ordy = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          r0, r1, out_valid, out_last, out_id;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg0;

    logic          b_v0 = 1'b1, b_v1 = 1'b1, b_ordy = 1'b1;
    logic [DW-1:0] b_d0 = 10'd5, b_d1 = 10'd9;
    logic          b_r0, b_r1, b_valid, b_last, b_id;
    logic [DW-1:0] b_data;
    logic [1:0]    dbg1;

    int checks = 0;
    int errors = 0;

    int m_owner, m_beats, m_last;
    int seq0 = 0, seq1 = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          rdy;
        logic [14:0]   exp;
    } vec_t;
    vec_t tbl[10];

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    helper_axis_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .input_0_valid(v0), .input_0_data(d0), .input_0_ready(r0),
        .input_1_valid(v1), .input_1_data(d1), .input_1_ready(r1),
        .output_valid(out_valid), .output_data(out_data), .output_last(out_last),
        .output_id(out_id), .output_ready(ordy), .debug_state(dbg0)
    );

    helper_axis_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut_b1 (
        .clk(clk), .rst(rst),
        .input_0_valid(b_v0), .input_0_data(b_d0), .input_0_ready(b_r0),
        .input_1_valid(b_v1), .input_1_data(b_d1), .input_1_ready(b_r1),
        .output_valid(b_valid), .output_data(b_data), .output_last(b_last),
        .output_id(b_id), .output_ready(b_ordy), .debug_state(dbg1)
    );

    function automatic logic [14:0] pk(logic v, logic [DW-1:0] d, logic l, logic id, logic a, logic b);
        return {v, d, l, id, a, b};
    endfunction

    function automatic logic [14:0] actual();
        return {out_valid, out_data, out_last, out_id, r0, r1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = 1;
    endtask

    task automatic model_expect(output logic [14:0] e);
        logic          vin[2];
        logic [DW-1:0] din[2];
        logic          rr[2];
        logic          ev;
        vin[0] = v0; vin[1] = v1; din[0] = d0; din[1] = d1;
        rr[0] = 1'b0; rr[1] = 1'b0;
        if (m_owner < 0) begin
            e = '0;
        end else begin
            ev = vin[m_owner];
            rr[m_owner] = ordy;
            e = pk(ev, din[m_owner], ev && (m_beats == BL - 1), m_owner[0], rr[0], rr[1]);
        end
    endtask

    task automatic model_advance();
        logic vin[2];
        vin[0] = v0; vin[1] = v1;
        if (m_owner < 0) begin
            if (v0 && v1)  m_owner = (m_last == 1) ? 0 : 1;
            else if (v0)   m_owner = 0;
            else if (v1)   m_owner = 1;
        end else if (vin[m_owner] && ordy) begin
            m_beats++;
            if (m_beats == BL) begin
                m_beats = 0;
                m_last  = m_owner;
                if (vin[1 - m_owner])    m_owner = 1 - m_owner;
                else if (!vin[m_owner])  m_owner = -1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One cycle: compare at negedge against the model, score accepted beats, advance.
    task automatic step(input string name);
        logic [14:0]   e;
        logic [DW-1:0] got;
        logic          hs0, hs1;
        @(negedge clk);
        model_expect(e);
        chk(name, {17'd0, actual()}, {17'd0, e});
        if (e[14] && ordy) exp_q.push_back(e[13:4]);
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_beat", 32'd1, 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("sb_data", {22'd0, out_data}, {22'd0, got});
            end
        end
        hs0 = v0 && r0;
        hs1 = v1 && r1;
        model_advance();
        @(posedge clk);
        #1;
        if (hs0) seq0++;
        if (hs1) seq1++;
        d0 = {1'b0, 9'(seq0)};
        d1 = {1'b1, 9'(seq1)};
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        tbl[0] = '{1'b1, 10'd0, 1'b1, 10'd512, 1'b1, pk(0, 10'd0,   0, 0, 0, 0)};
        tbl[1] = '{1'b1, 10'd0, 1'b1, 10'd512, 1'b1, pk(1, 10'd0,   0, 0, 1, 0)};
        tbl[2] = '{1'b1, 10'd1, 1'b1, 10'd512, 1'b1, pk(1, 10'd1,   0, 0, 1, 0)};
        tbl[3] = '{1'b1, 10'd2, 1'b1, 10'd512, 1'b1, pk(1, 10'd2,   0, 0, 1, 0)};
        tbl[4] = '{1'b1, 10'd3, 1'b1, 10'd512, 1'b1, pk(1, 10'd3,   1, 0, 1, 0)};
        tbl[5] = '{1'b1, 10'd4, 1'b1, 10'd512, 1'b1, pk(1, 10'd512, 0, 1, 0, 1)};
        tbl[6] = '{1'b1, 10'd4, 1'b1, 10'd513, 1'b1, pk(1, 10'd513, 0, 1, 0, 1)};
        tbl[7] = '{1'b1, 10'd4, 1'b1, 10'd514, 1'b1, pk(1, 10'd514, 0, 1, 0, 1)};
        tbl[8] = '{1'b1, 10'd4, 1'b1, 10'd515, 1'b1, pk(1, 10'd515, 1, 1, 0, 1)};
        tbl[9] = '{1'b1, 10'd4, 1'b1, 10'd516, 1'b1, pk(1, 10'd4,   0, 0, 1, 0)};

        v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {17'd0, actual()}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            v0 = tbl[i].v0; d0 = tbl[i].d0; v1 = tbl[i].v1; d1 = tbl[i].d1; ordy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("table_%0d", i), {17'd0, actual()}, {17'd0, tbl[i].exp});
            @(posedge clk);
            #1;
        end

        // Only source 1 requesting.
        v0 = 1'b0; v1 = 1'b1; ordy = 1'b1;
        reset_dut();
        repeat (10) step("only_src1");

        // Granted source drops valid mid-burst; grant must hold.
        v0 = 1'b1; v1 = 1'b1;
        reset_dut();
        repeat (3) step("drop_pre");
        v0 = 1'b0;
        repeat (3) step("drop_hold");
        v0 = 1'b1;
        repeat (4) step("drop_resume");

        // Downstream ready toggling during a burst.
        v0 = 1'b1; v1 = 1'b0;
        reset_dut();
        step("toggle_idle");
        for (int i = 0; i < 8; i++) begin
            ordy = (i % 2 == 0);
            step("toggle_beat");
        end
        ordy = 1'b1;
        v1 = 1'b1;
        repeat (2) step("toggle_after");

        // Asynchronous reset in the middle of a GRANT1 burst.
        v0 = 1'b0; v1 = 1'b1; ordy = 1'b1;
        reset_dut();
        repeat (3) step("pre_async");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {17'd0, actual()}, 32'd0);
        rst = 1'b0;
        model_reset();
        v0 = 1'b1;
        repeat (6) step("post_async");

        // Random traffic.
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            v0   = ($urandom_range(0, 3) != 0);
            v1   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step("random");
        end
        chk("sb_drain", exp_q.size(), 32'd0);

        // BURST_LEN=1 instance: strict alternation, last on every beat.
        reset_dut();
        @(negedge clk);
        chk("b1_idle", {20'd0, b_valid, b_data, b_last}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b1_beat_%0d", k),
                {19'd0, b_valid, b_data, b_last, b_id},
                {19'd0, 1'b1, ((k % 2) == 1) ? 10'd5 : 10'd9, 1'b1, ((k % 2) == 0)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
